// File: rtl/fios_ctrl_pkg.sv
// Shared types and constants for the FIOS first-PE batch controller.
// State encodings are fixed because downstream PEs decode the delayed state.
package fios_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT          = 4'd0,
    ST_A_B0          = 4'd1,
    ST_RES_P_PRIME_0 = 4'd2,
    ST_M_P0          = 4'd3,
    ST_A_BJ          = 4'd4,
    ST_M_PJ          = 4'd5,
    ST_LAST_A_BJ     = 4'd6,
    ST_LAST_M_PJ     = 4'd7,
    ST_RES_SHIFT     = 4'd8
  } state_t;

  localparam logic [8:0] OPM_INIT_CORR = 9'b000000101;
  localparam logic [8:0] OPM_INIT      = 9'b110000101;
  localparam logic [8:0] OPM_AB0       = 9'b000000101;
  localparam logic [8:0] OPM_RES_PP0   = 9'b110000101;
  localparam logic [8:0] OPM_MP        = 9'b111100101;
  localparam logic [8:0] OPM_ABJ       = 9'b000100101;
  localparam logic [8:0] OPM_LAST_MP   = 9'b001100000;
  localparam logic [8:0] OPM_SHIFT     = 9'b000100000;

  localparam logic [1:0] MUX_SEL_0 = 2'd0;
  localparam logic [1:0] MUX_SEL_1 = 2'd1;
  localparam logic [1:0] MUX_SEL_2 = 2'd2;

  // Per-cycle DSP control word as decoded from the state.
  typedef struct packed {
    logic       ready;
    logic       a_reg_en;
    logic       m_reg_en;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic       creg_en;
    logic [8:0] opmode;
    logic       res_delay_en;
    logic       a_shift;
    logic       b_fetch;
    logic       p_fetch;
    logic       res_push;
    logic       done;
  } ctrl_word_t;

endpackage

// File: rtl/fios_control_batch_if.sv
// Start handshake and control-word bundle between the FIOS controller and its host/array.
interface fios_control_batch_if #(
  parameter int BATCH_MAX = 8
) ();
  localparam int BW = $clog2(BATCH_MAX + 1);

  logic          start_i;
  logic [BW-1:0] batch_len_i;
  logic          abort_i;
  logic          ready_o;
  logic          busy_o;
  logic          a_reg_en_o;
  logic          m_reg_en_o;
  logic [1:0]    mux_A_sel_o;
  logic [1:0]    mux_B_sel_o;
  logic [1:0]    mux_C_sel_o;
  logic          CREG_en_o;
  logic [8:0]    OPMODE_o;
  logic          RES_delay_en_o;
  logic          a_shift_o;
  logic          b_fetch_o;
  logic          p_fetch_o;
  logic          RES_push_o;
  logic          done_o;
  logic          last_o;

  modport master (
    output start_i, batch_len_i, abort_i,
    input  ready_o, busy_o, a_reg_en_o, m_reg_en_o, mux_A_sel_o, mux_B_sel_o,
           mux_C_sel_o, CREG_en_o, OPMODE_o, RES_delay_en_o, a_shift_o,
           b_fetch_o, p_fetch_o, RES_push_o, done_o, last_o
  );

  modport slave (
    input  start_i, batch_len_i, abort_i,
    output ready_o, busy_o, a_reg_en_o, m_reg_en_o, mux_A_sel_o, mux_B_sel_o,
           mux_C_sel_o, CREG_en_o, OPMODE_o, RES_delay_en_o, a_shift_o,
           b_fetch_o, p_fetch_o, RES_push_o, done_o, last_o
  );
endinterface

// File: rtl/fios_op_counter.sv
// Generic up-counter with synchronous clear (dominant over enable).
module fios_op_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fios_control_batch.sv
// Moore control FSM for the first PE of the FIOS Montgomery array, with batched starts.
// Optional abort support is compiled in with `define FIOS_CTRL_ABORT_EN.
module fios_control_batch
  import fios_ctrl_pkg::*;
#(
  parameter int S              = 16,
  parameter int BATCH_MAX      = 8,
  parameter int CREG           = 0,
  parameter int ADD_CORRECTION = 0
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  fios_control_batch_if.slave  ctrl
);

  localparam int LW = $clog2(S);
  localparam int BW = $clog2(BATCH_MAX + 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(S - 2);

  state_t        state_reg;
  state_t        state_next;
  logic [BW-1:0] batch_len_reg;
  logic [BW-1:0] batch_len_eff;
  logic [LW-1:0] loop_cnt;
  logic [BW-1:0] op_cnt;
  logic          handshake;
  logic          abort_hit;
  logic          last_op;
  ctrl_word_t    cw;

  assign handshake = (state_reg == ST_INIT) && ctrl.start_i;
  assign last_op   = (op_cnt == batch_len_reg - BW'(1));

`ifdef FIOS_CTRL_ABORT_EN
  assign abort_hit = ctrl.abort_i && (state_reg != ST_INIT);
`else
  logic unused_abort;
  assign unused_abort = ctrl.abort_i;
  assign abort_hit    = 1'b0;
`endif

  // Zero means one multiplication; oversize requests saturate.
  always_comb begin
    batch_len_eff = ctrl.batch_len_i;
    if (ctrl.batch_len_i == '0) begin
      batch_len_eff = BW'(1);
    end else if (ctrl.batch_len_i > BW'(BATCH_MAX)) begin
      batch_len_eff = BW'(BATCH_MAX);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg     <= ST_INIT;
      batch_len_reg <= BW'(1);
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        batch_len_reg <= batch_len_eff;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:          if (ctrl.start_i) state_next = ST_A_B0;
      ST_A_B0:          state_next = ST_RES_P_PRIME_0;
      ST_RES_P_PRIME_0: state_next = ST_M_P0;
      ST_M_P0:          state_next = (S == 2) ? ST_LAST_A_BJ : ST_A_BJ;
      ST_A_BJ:          state_next = ST_M_PJ;
      ST_M_PJ:          state_next = (loop_cnt == LOOP_LAST) ? ST_LAST_A_BJ : ST_A_BJ;
      ST_LAST_A_BJ:     state_next = ST_LAST_M_PJ;
      ST_LAST_M_PJ:     state_next = ST_RES_SHIFT;
      ST_RES_SHIFT:     state_next = last_op ? ST_INIT : ST_A_B0;
      default:          state_next = ST_INIT;
    endcase
    if (abort_hit) begin
      state_next = ST_INIT;
    end
  end

  fios_op_counter #(.WIDTH(LW)) u_loop_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear   ((state_reg == ST_INIT) || (state_reg == ST_RES_SHIFT) || abort_hit),
    .enable  ((state_reg == ST_M_P0) || (state_reg == ST_M_PJ) || (state_reg == ST_LAST_M_PJ)),
    .count   (loop_cnt)
  );

  fios_op_counter #(.WIDTH(BW)) u_op_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear   (handshake || abort_hit),
    .enable  (state_reg == ST_RES_SHIFT),
    .count   (op_cnt)
  );

  always_comb begin
    cw = '0;
    case (state_reg)
      ST_INIT: begin
        cw.ready    = 1'b1;
        cw.a_reg_en = 1'b1;
        cw.creg_en  = 1'b1;
        cw.opmode   = (ADD_CORRECTION != 0) ? OPM_INIT_CORR : OPM_INIT;
      end
      ST_A_B0: begin
        cw.mux_a_sel = MUX_SEL_1;
        cw.mux_b_sel = MUX_SEL_1;
        cw.mux_c_sel = MUX_SEL_1;
        cw.creg_en   = 1'b1;
        cw.opmode    = OPM_AB0;
        cw.a_shift   = 1'b1;
      end
      ST_RES_P_PRIME_0: begin
        cw.m_reg_en  = 1'b1;
        cw.mux_a_sel = MUX_SEL_1;
        cw.mux_b_sel = MUX_SEL_2;
        cw.mux_c_sel = (CREG != 0) ? MUX_SEL_2 : MUX_SEL_1;
        cw.creg_en   = 1'b1;
        cw.opmode    = OPM_RES_PP0;
        cw.b_fetch   = 1'b1;
      end
      ST_M_P0, ST_M_PJ: begin
        cw.mux_a_sel = MUX_SEL_0;
        cw.mux_b_sel = MUX_SEL_0;
        cw.mux_c_sel = MUX_SEL_2;
        cw.opmode    = OPM_MP;
        cw.p_fetch   = 1'b1;
        cw.res_push  = (state_reg == ST_M_PJ);
      end
      ST_A_BJ: begin
        cw.mux_a_sel = MUX_SEL_2;
        cw.mux_b_sel = MUX_SEL_2;
        cw.mux_c_sel = MUX_SEL_2;
        cw.creg_en   = 1'b1;
        cw.opmode    = OPM_ABJ;
        cw.b_fetch   = 1'b1;
      end
      ST_LAST_A_BJ: begin
        cw.mux_a_sel = MUX_SEL_2;
        cw.mux_b_sel = MUX_SEL_2;
        cw.mux_c_sel = MUX_SEL_0;
        cw.opmode    = OPM_ABJ;
      end
      ST_LAST_M_PJ: begin
        cw.opmode       = OPM_LAST_MP;
        cw.res_push     = 1'b1;
        cw.res_delay_en = 1'b1;
      end
      ST_RES_SHIFT: begin
        cw.a_reg_en     = 1'b1;
        cw.opmode       = OPM_SHIFT;
        cw.res_push     = 1'b1;
        cw.res_delay_en = 1'b1;
        cw.done         = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  assign ctrl.ready_o        = cw.ready;
  assign ctrl.busy_o         = ~cw.ready;
  assign ctrl.a_reg_en_o     = cw.a_reg_en;
  assign ctrl.m_reg_en_o     = cw.m_reg_en;
  assign ctrl.mux_A_sel_o    = cw.mux_a_sel;
  assign ctrl.mux_B_sel_o    = cw.mux_b_sel;
  assign ctrl.mux_C_sel_o    = cw.mux_c_sel;
  assign ctrl.CREG_en_o      = cw.creg_en;
  assign ctrl.OPMODE_o       = cw.opmode;
  assign ctrl.RES_delay_en_o = cw.res_delay_en;
  assign ctrl.a_shift_o      = cw.a_shift;
  assign ctrl.b_fetch_o      = cw.b_fetch;
  assign ctrl.p_fetch_o      = cw.p_fetch;
  assign ctrl.RES_push_o     = cw.res_push;
  assign ctrl.done_o         = cw.done;
  assign ctrl.last_o         = cw.done && last_op;

endmodule
